// File: rtl/regfile_writeback_arbiter.sv
// Purpose : shares one register-file write port between NUM_REQ writeback sources via one-entry holding buffers.
// Latency : transfer at edge E0, grant at E1, write_en high during E1..E2 (register file writes at E2).
// Backpres: req_ready[i] is the registered inverse of buffer-i full; low from the transfer edge until its grant edge.
//
// Ports:
//   clock, reset          - single rising-edge clock, asynchronous active-low reset
//   req_valid/addr/data   - per-requester write offer (slice i belongs to requester i)
//   req_ready             - per-requester buffer empty
//   write_en/_reg_addr/_reg_data_in - registered register-file write port
//   grant_id              - requester whose write is currently on the outputs
//   busy                  - any buffer full or a write in flight
//
// Build option: define WB_FIXED_PRIORITY_EN to grant the lowest-index full buffer
// instead of round-robin. Ports and latency are the same in both builds.

module regfile_writeback_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int ADDRESS_WIDTH = 5,
    parameter int REG_SIZE      = 32,
    parameter int ID_WIDTH      = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*REG_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write_en,
    output logic [ADDRESS_WIDTH-1:0]      write_reg_addr,
    output logic [REG_SIZE-1:0]           write_reg_data_in,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    // Holding buffers
    logic [NUM_REQ-1:0]       r_full;
    logic [ADDRESS_WIDTH-1:0] r_addr [NUM_REQ];
    logic [REG_SIZE-1:0]      r_data [NUM_REQ];

    // Output registers
    logic                     r_write_en;
    logic [ADDRESS_WIDTH-1:0] r_write_addr;
    logic [REG_SIZE-1:0]      r_write_data;
    logic [ID_WIDTH-1:0]      r_grant_id;

    // Grant selection
    logic                     w_gnt_vld;
    logic [NUM_REQ-1:0]       w_gnt_oh;
    logic [ID_WIDTH-1:0]      w_gnt_idx;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [REG_SIZE-1:0]      w_sel_data;

`ifdef WB_FIXED_PRIORITY_EN
    // Lowest index wins; a continuously refilled low buffer can starve higher ones.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_gnt_vld && r_full[j]) begin
                w_gnt_vld   = 1'b1;
                w_gnt_oh[j] = 1'b1;
                w_gnt_idx   = ID_WIDTH'(j);
            end
        end
    end
`else
    logic [ID_WIDTH-1:0] r_last_grant;

    // Search starts one past the last winner and wraps, so every full buffer
    // is served within NUM_REQ-1 grants of another requester.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_gnt_vld && r_full[j] &&
                    (j == ((int'(r_last_grant) + k) % NUM_REQ))) begin
                    w_gnt_vld   = 1'b1;
                    w_gnt_oh[j] = 1'b1;
                    w_gnt_idx   = ID_WIDTH'(j);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
        end else if (w_gnt_vld) begin
            r_last_grant <= w_gnt_idx;
        end
    end
`endif

    // One-hot mux of the winning buffer
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_gnt_oh[j]) begin
                w_sel_addr = r_addr[j];
                w_sel_data = r_data[j];
            end
        end
    end

    // Buffer fill/drain. Fill needs empty and drain needs full, so the two
    // never collide on the same buffer in one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_full <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !r_full[i]) begin
                    r_full[i] <= 1'b1;
                    r_addr[i] <= req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    r_data[i] <= req_data[i*REG_SIZE +: REG_SIZE];
                end else if (w_gnt_oh[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Output port registers. A write to register 0 still uses its grant slot
    // and updates addr/data/id, but write_en is suppressed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_grant_id   <= '0;
        end else if (w_gnt_vld) begin
            r_write_en   <= (w_sel_addr != '0);
            r_write_addr <= w_sel_addr;
            r_write_data <= w_sel_data;
            r_grant_id   <= w_gnt_idx;
        end else begin
            r_write_en   <= 1'b0;
        end
    end

    assign req_ready         = ~r_full;
    assign write_en          = r_write_en;
    assign write_reg_addr    = r_write_addr;
    assign write_reg_data_in = r_write_data;
    assign grant_id          = r_grant_id;
    assign busy              = (|r_full) | r_write_en;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Purpose : directed-vector bench for regfile_writeback_arbiter with hand-computed expectations.
// Latency : inputs driven and outputs sampled on the falling edge; one tick = posedge then negedge.
// Backpres: back-to-back stimulus advances requester data only on an observed valid&&ready edge.

module tb_regfile_writeback_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int IW = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic             write_en;
    logic [AW-1:0]    write_reg_addr;
    logic [DW-1:0]    write_reg_data_in;
    logic [IW-1:0]    grant_id;
    logic             busy;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_writeback_arbiter #(
        .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .REG_SIZE(DW), .ID_WIDTH(IW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .write_en(write_en),
        .write_reg_addr(write_reg_addr), .write_reg_data_in(write_reg_data_in),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [IW-1:0] gid,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        check_vec({tag, "_we"},   64'(write_en), 64'(we));
        check_vec({tag, "_gid"},  64'(grant_id), 64'(gid));
        check_vec({tag, "_addr"}, 64'(write_reg_addr), 64'(a));
        check_vec({tag, "_data"}, 64'(write_reg_data_in), 64'(d));
    endtask

    initial begin
        logic [11:0] we_trace;
        logic        xfer;
        logic        any_we;
        int          k;
        int          nw;
        logic [DW-1:0] exp_seq [3];

        // ---------------- reset state ----------------
        @(negedge clock);
        @(negedge clock);
        check_vec("rst_ready", 64'(req_ready), 64'h7);
        check_write("rst", 1'b0, 2'd0, 5'd0, 32'd0);
        check_vec("rst_busy", 64'(busy), 64'h0);
        reset = 1'b1;
        tick();

        // ---------------- round-robin, all three at once ----------------
        set_req(0, 5'd1, 32'h101);
        set_req(1, 5'd2, 32'h102);
        set_req(2, 5'd3, 32'h103);
        for (int pass = 0; pass < 2; pass++) begin
            req_valid = 3'b111;
            tick();
            req_valid = 3'b000;
            check_vec("rr_ready0", 64'(req_ready), 64'h0);
            check_vec("rr_we0", 64'(write_en), 64'h0);
            tick();
            check_write("rr_g0", 1'b1, 2'd0, 5'd1, 32'h101);
            check_vec("rr_ready1", 64'(req_ready), 64'h1);
            tick();
            check_write("rr_g1", 1'b1, 2'd1, 5'd2, 32'h102);
            check_vec("rr_ready2", 64'(req_ready), 64'h3);
            tick();
            check_write("rr_g2", 1'b1, 2'd2, 5'd3, 32'h103);
            check_vec("rr_ready3", 64'(req_ready), 64'h7);
            tick();
            check_vec("rr_idle_we", 64'(write_en), 64'h0);
            check_vec("rr_idle_busy", 64'(busy), 64'h0);
        end

        // ---------------- single write ----------------
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        check_vec("single_ready_low", 64'(req_ready), 64'h6);
        check_vec("single_busy", 64'(busy), 64'h1);
        check_vec("single_we_pre", 64'(write_en), 64'h0);
        tick();
        check_write("single", 1'b1, 2'd0, 5'd5, 32'hDEADBEEF);
        check_vec("single_ready_back", 64'(req_ready), 64'h7);
        tick();
        check_vec("single_we_done", 64'(write_en), 64'h0);
        check_vec("single_addr_hold", 64'(write_reg_addr), 64'd5);
        check_vec("single_busy_done", 64'(busy), 64'h0);

        // ---------------- register 0 (leaves last_grant = 1) ----------------
        set_req(1, 5'd0, 32'd7);
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        check_vec("r0_ready_low", 64'(req_ready), 64'h5);
        tick();
        check_vec("r0_we", 64'(write_en), 64'h0);
        check_vec("r0_gid", 64'(grant_id), 64'd1);
        check_vec("r0_addr", 64'(write_reg_addr), 64'd0);
        check_vec("r0_ready_back", 64'(req_ready), 64'h7);
        check_vec("r0_busy", 64'(busy), 64'h0);

        // ---------------- last_grant = 1, buffers 0 and 2 full ----------------
        set_req(0, 5'd10, 32'hA0);
        set_req(2, 5'd12, 32'hA2);
        req_valid = 3'b101;
        tick();
        req_valid = 3'b000;
        tick();
`ifdef WB_FIXED_PRIORITY_EN
        check_write("wrap_first", 1'b1, 2'd0, 5'd10, 32'hA0);
        tick();
        check_write("wrap_second", 1'b1, 2'd2, 5'd12, 32'hA2);
`else
        check_write("wrap_first", 1'b1, 2'd2, 5'd12, 32'hA2);
        tick();
        check_write("wrap_second", 1'b1, 2'd0, 5'd10, 32'hA0);
`endif
        tick();
        check_vec("wrap_idle", 64'(write_en), 64'h0);

        // ---------------- back-to-back on requester 2 ----------------
        exp_seq[0] = 32'd1;
        exp_seq[1] = 32'd2;
        exp_seq[2] = 32'd3;
        we_trace = '0;
        nw = 0;
        k = 1;
        set_req(2, 5'd20, 32'd1);
        req_valid = 3'b100;
        for (int c = 0; c < 12; c++) begin
            xfer = req_valid[2] && req_ready[2];
            tick();
            we_trace[c] = write_en;
            if (write_en) begin
                if (nw < 3) check_vec("b2b_data", 64'(write_reg_data_in), 64'(exp_seq[nw]));
                nw++;
            end
            if (xfer) begin
                k++;
                if (k > 3) req_valid = 3'b000;
                else       set_req(2, 5'd20, DW'(k));
            end
        end
        check_vec("b2b_pattern", 64'(we_trace), 64'b0000_0010_1010);
        check_vec("b2b_count", 64'(nw), 64'd3);

`ifdef WB_FIXED_PRIORITY_EN
        // ---------------- fixed priority: 0 and 1 saturate, 2 starves ----------------
        set_req(0, 5'd1, 32'hF0);
        set_req(1, 5'd2, 32'hF1);
        set_req(2, 5'd3, 32'hF2);
        req_valid = 3'b111;
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            check_vec("fp_we", 64'(write_en), 64'h1);
            check_vec("fp_gid", 64'(grant_id), 64'(c % 2));
        end
        req_valid = 3'b000;
        tick();
        tick();
        tick();
        tick();
`endif

        // ---------------- reset mid-operation ----------------
        set_req(0, 5'd8, 32'hB0);
        set_req(2, 5'd9, 32'hB2);
        req_valid = 3'b101;
        tick();
        req_valid = 3'b000;
        check_vec("mid_ready_pre", 64'(req_ready), 64'h2);
        #2;
        reset = 1'b0;
        #1;
        check_vec("mid_ready", 64'(req_ready), 64'h7);
        check_vec("mid_we", 64'(write_en), 64'h0);
        check_vec("mid_busy", 64'(busy), 64'h0);
        tick();
        reset = 1'b1;
        any_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            any_we = any_we | write_en;
        end
        check_vec("mid_no_write", 64'(any_we), 64'h0);
        check_vec("mid_gid", 64'(grant_id), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
